// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states, datapath selects.
// Optional feature macro used by importers: MC_CTRL_ILLEGAL_OP_EN.
package mc_controller_pkg;

   localparam int unsigned OP_W       = 7;
   localparam int unsigned F3_W       = 3;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned ALU_CTRL_W = 3;

   localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
   } state_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_control_t;

   typedef enum logic [SEL_W-1:0] {
      IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11
   } imm_src_t;

   typedef enum logic [SEL_W-1:0] {
      RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [SEL_W-1:0] {
      SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10
   } alu_src_a_t;

   typedef enum logic [SEL_W-1:0] {
      SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
   } alu_src_b_t;

   // Datapath control word, excluding the ALU operation which comes from the decoder.
   typedef struct packed {
      logic        pc_write;
      logic        adr_src;
      logic        mem_write;
      logic        ir_write;
      logic        reg_write;
      result_src_t result_src;
      alu_src_a_t  alu_src_a;
      alu_src_b_t  alu_src_b;
      imm_src_t    imm_src;
      logic        mem_timeout;
   } ctrl_out_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and status in, selects and strobes out.
// illegal_instr exists only when MC_CTRL_ILLEGAL_OP_EN is defined.
interface mc_controller_if;
   import mc_controller_pkg::*;

   logic [OP_W-1:0]       op;
   logic [F3_W-1:0]       funct3;
   logic                  funct7b5;
   logic                  zero;
   logic                  mem_ready;

   logic                  pc_write;
   logic                  adr_src;
   logic                  mem_write;
   logic                  ir_write;
   logic                  reg_write;
   logic [SEL_W-1:0]      result_src;
   logic [SEL_W-1:0]      alu_src_a;
   logic [SEL_W-1:0]      alu_src_b;
   logic [SEL_W-1:0]      imm_src;
   logic [ALU_CTRL_W-1:0] alu_control;
   logic                  mem_timeout;
`ifdef MC_CTRL_ILLEGAL_OP_EN
   logic                  illegal_instr;
`endif

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
`ifdef MC_CTRL_ILLEGAL_OP_EN
      output illegal_instr,
`endif
      output pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, imm_src, alu_control, mem_timeout
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
`ifdef MC_CTRL_ILLEGAL_OP_EN
      input  illegal_instr,
`endif
      input  pc_write, adr_src, mem_write, ir_write, reg_write,
             result_src, alu_src_a, alu_src_b, imm_src, alu_control, mem_timeout
   );

endinterface

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU operation select from the FSM's alu_op class and the instruction funct fields.
module mc_controller_alu_decoder
   import mc_controller_pkg::*;
(
   input  alu_op_t             i_alu_op,
   input  logic [F3_W-1:0]     i_funct3,
   input  logic                i_funct7b5,
   input  logic                i_op5,
   output alu_control_t        o_alu_control
);

   // Only R-type (op[5]=1) distinguishes sub from add; addi ignores instr[30].
   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_alu_op)
         ALU_OP_SUB: o_alu_control = ALU_SUB;
         ALU_OP_FUNCT: begin
            case (i_funct3)
               3'b000:  if (i_op5 && i_funct7b5) o_alu_control = ALU_SUB;
               3'b010:  o_alu_control = ALU_SLT;
               3'b110:  o_alu_control = ALU_OR;
               3'b111:  o_alu_control = ALU_AND;
               default: o_alu_control = ALU_ADD;
            endcase
         end
         default: o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM with memory-ready stall and wait timeout.
// Define MC_CTRL_ILLEGAL_OP_EN to trap unknown opcodes in a sticky ILLEGAL state.
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic           clk,
   input  logic           reset,
   mc_controller_if.master bus
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_wait;
   logic             w_timeout;
   alu_op_t          w_alu_op;
   alu_control_t     w_alu_control;
   ctrl_out_t        w_out;

   mc_controller_alu_decoder u_alu_decoder (
      .i_alu_op      (w_alu_op),
      .i_funct3      (bus.funct3),
      .i_funct7b5    (bus.funct7b5),
      .i_op5         (bus.op[5]),
      .o_alu_control (w_alu_control)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Wait-cycle counter; any completion, timeout or non-wait state restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (!w_wait || bus.mem_ready || w_timeout || (TIMEOUT_CYCLES == 0))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CNT_W'(1);
   end

   always_comb begin
      w_next    = r_state;
      w_alu_op  = ALU_OP_ADD;
      w_wait    = 1'b0;
      w_timeout = 1'b0;
      w_out     = '0;

      case (r_state)
         S_FETCH: begin
            w_wait             = 1'b1;
            w_out.alu_src_b    = SRCB_FOUR;
            w_out.result_src   = RES_ALURESULT;
            w_out.ir_write     = bus.mem_ready;
            w_out.pc_write     = bus.mem_ready;
            if (bus.mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_out.alu_src_a = SRCA_OLDPC;
            w_out.alu_src_b = SRCB_IMM;
            w_out.imm_src   = IMM_B;
            case (bus.op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXECUTER;
               OP_ITYPE:     w_next = S_EXECUTEI;
               OP_BEQ:       w_next = S_BEQ;
               OP_JAL:       w_next = S_JAL;
`ifdef MC_CTRL_ILLEGAL_OP_EN
               default:      w_next = S_ILLEGAL;
`else
               default:      w_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            w_out.alu_src_a = SRCA_RD1;
            w_out.alu_src_b = SRCB_IMM;
            w_out.imm_src   = (bus.op == OP_SW) ? IMM_S : IMM_I;
            w_next          = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            w_wait        = 1'b1;
            w_out.adr_src = 1'b1;
            if (bus.mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_out.result_src = RES_MEMDATA;
            w_out.reg_write  = 1'b1;
            w_next           = S_FETCH;
         end
         S_MEMWRITE: begin
            w_wait          = 1'b1;
            w_out.adr_src   = 1'b1;
            w_out.mem_write = 1'b1;
            if (bus.mem_ready) w_next = S_FETCH;
         end
         S_EXECUTER: begin
            w_out.alu_src_a = SRCA_RD1;
            w_out.alu_src_b = SRCB_RD2;
            w_alu_op        = ALU_OP_FUNCT;
            w_next          = S_ALUWB;
         end
         S_EXECUTEI: begin
            w_out.alu_src_a = SRCA_RD1;
            w_out.alu_src_b = SRCB_IMM;
            w_out.imm_src   = IMM_I;
            w_alu_op        = ALU_OP_FUNCT;
            w_next          = S_ALUWB;
         end
         S_ALUWB: begin
            w_out.result_src = RES_ALUOUT;
            w_out.reg_write  = 1'b1;
            w_next           = S_FETCH;
         end
         S_BEQ: begin
            w_out.alu_src_a  = SRCA_RD1;
            w_out.alu_src_b  = SRCB_RD2;
            w_out.result_src = RES_ALUOUT;
            w_out.pc_write   = bus.zero;
            w_alu_op         = ALU_OP_SUB;
            w_next           = S_FETCH;
         end
         S_JAL: begin
            w_out.alu_src_a  = SRCA_OLDPC;
            w_out.alu_src_b  = SRCB_FOUR;
            w_out.result_src = RES_ALUOUT;
            w_out.pc_write   = 1'b1;
            w_out.reg_write  = 1'b1;
            w_next           = S_FETCH;
         end
`ifdef MC_CTRL_ILLEGAL_OP_EN
         S_ILLEGAL: w_next = S_ILLEGAL;
`endif
         default: w_next = S_FETCH;
      endcase

      // Timeout aborts the wait; a same-cycle mem_ready completes normally instead.
      if (w_wait && !bus.mem_ready && (TIMEOUT_CYCLES != 0) &&
          (r_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
         w_timeout       = 1'b1;
         w_next          = S_FETCH;
         w_out.pc_write  = 1'b0;
         w_out.ir_write  = 1'b0;
         w_out.mem_write = 1'b0;
         w_out.reg_write = 1'b0;
      end
      w_out.mem_timeout = w_timeout;

      if (!reset) w_out = '0;
   end

   assign bus.pc_write    = w_out.pc_write;
   assign bus.adr_src     = w_out.adr_src;
   assign bus.mem_write   = w_out.mem_write;
   assign bus.ir_write    = w_out.ir_write;
   assign bus.reg_write   = w_out.reg_write;
   assign bus.result_src  = w_out.result_src;
   assign bus.alu_src_a   = w_out.alu_src_a;
   assign bus.alu_src_b   = w_out.alu_src_b;
   assign bus.imm_src     = w_out.imm_src;
   assign bus.mem_timeout = w_out.mem_timeout;
   assign bus.alu_control = reset ? w_alu_control : ALU_CTRL_W'(0);
`ifdef MC_CTRL_ILLEGAL_OP_EN
   assign bus.illegal_instr = reset && (r_state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (TIMEOUT_CYCLES=4); honours MC_CTRL_ILLEGAL_OP_EN.
module tb_mc_controller;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mc_controller_if bus();

   mc_controller #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, imm_src, alu_control, mem_timeout}
   localparam logic [16:0] E_ZERO    = 17'b0_0_0_0_0_00_00_00_00_000_0;
   localparam logic [16:0] E_FETCH   = 17'b1_0_0_1_0_10_00_10_00_000_0;
   localparam logic [16:0] E_FETCHNR = 17'b0_0_0_0_0_10_00_10_00_000_0;
   localparam logic [16:0] E_FETCHTO = 17'b0_0_0_0_0_10_00_10_00_000_1;
   localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_00_01_01_10_000_0;
   localparam logic [16:0] E_EXR_ADD = 17'b0_0_0_0_0_00_10_00_00_000_0;
   localparam logic [16:0] E_EXR_SUB = 17'b0_0_0_0_0_00_10_00_00_001_0;
   localparam logic [16:0] E_EXR_SLT = 17'b0_0_0_0_0_00_10_00_00_101_0;
   localparam logic [16:0] E_EXI_OR  = 17'b0_0_0_0_0_00_10_01_00_011_0;
   localparam logic [16:0] E_EXI_ADD = 17'b0_0_0_0_0_00_10_01_00_000_0;
   localparam logic [16:0] E_ALUWB   = 17'b0_0_0_0_1_00_00_00_00_000_0;
   localparam logic [16:0] E_ADR_LW  = 17'b0_0_0_0_0_00_10_01_00_000_0;
   localparam logic [16:0] E_ADR_SW  = 17'b0_0_0_0_0_00_10_01_01_000_0;
   localparam logic [16:0] E_MEMRD   = 17'b0_1_0_0_0_00_00_00_00_000_0;
   localparam logic [16:0] E_MEMWB   = 17'b0_0_0_0_1_01_00_00_00_000_0;
   localparam logic [16:0] E_MEMWR   = 17'b0_1_1_0_0_00_00_00_00_000_0;
   localparam logic [16:0] E_MWTO    = 17'b0_1_0_0_0_00_00_00_00_000_1;
   localparam logic [16:0] E_BEQ_T   = 17'b1_0_0_0_0_00_10_00_00_001_0;
   localparam logic [16:0] E_BEQ_N   = 17'b0_0_0_0_0_00_10_00_00_001_0;
   localparam logic [16:0] E_JAL     = 17'b1_0_0_0_1_00_01_10_00_000_0;

   function automatic logic [16:0] sig();
      return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
              bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
              bus.alu_control, bus.mem_timeout};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++;
         if (sig() !== E_ZERO) begin
            errors++;
            $display("FAIL reset_hold[%0d] got %b want %b", i, sig(), E_ZERO);
         end
      end
      @(negedge clk); bus.mem_ready = 1'b0; reset = 1'b1; #1;
      checks++;
      if (sig() !== E_FETCHNR) begin
         errors++;
         $display("FAIL reset_release got %b want %b", sig(), E_FETCHNR);
      end
   endtask

   task automatic test_rtype(input logic [2:0] f3, input logic f7b5, input logic [16:0] exp_exec);
      logic [16:0] exp [4];
      exp = '{E_FETCH, E_DECODE, exp_exec, E_ALUWB};
      bus.op = 7'b0110011; bus.funct3 = f3; bus.funct7b5 = f7b5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bus.mem_ready = 1'b1; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL rtype_f3_%b[%0d] got %b want %b", f3, i, sig(), exp[i]);
         end
      end
   endtask

   task automatic test_itype(input logic [2:0] f3, input logic f7b5, input logic [16:0] exp_exec);
      logic [16:0] exp [4];
      exp = '{E_FETCH, E_DECODE, exp_exec, E_ALUWB};
      bus.op = 7'b0010011; bus.funct3 = f3; bus.funct7b5 = f7b5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bus.mem_ready = 1'b1; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL itype_f3_%b[%0d] got %b want %b", f3, i, sig(), exp[i]);
         end
      end
   endtask

   task automatic test_lw_stall();
      logic [16:0] exp [8];
      logic        rdy [8];
      exp = '{E_FETCH, E_DECODE, E_ADR_LW, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); bus.mem_ready = rdy[i]; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL lw_stall[%0d] got %b want %b", i, sig(), exp[i]);
         end
      end
   endtask

   task automatic test_beq(input logic z);
      logic [16:0] exp [4];
      exp = '{E_FETCH, E_DECODE, (z ? E_BEQ_T : E_BEQ_N), E_FETCH};
      bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = z;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bus.mem_ready = 1'b1; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL beq_zero%b[%0d] got %b want %b", z, i, sig(), exp[i]);
         end
      end
      // Fourth cycle was a new fetch: move past DECODE with a NOP-free JAL-free R-type add
      bus.op = 7'b0110011; bus.zero = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
   endtask

   task automatic test_jal();
      logic [16:0] exp [3];
      exp = '{E_FETCH, E_DECODE, E_JAL};
      bus.op = 7'b1101111; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); bus.mem_ready = 1'b1; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL jal[%0d] got %b want %b", i, sig(), exp[i]);
         end
      end
   endtask

   task automatic test_sw_ready_wins();
      logic [16:0] exp [9];
      logic        rdy [9];
      exp = '{E_FETCH, E_DECODE, E_ADR_SW, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCHNR};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk); bus.mem_ready = rdy[i]; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL sw_ready_wins[%0d] got %b want %b", i, sig(), exp[i]);
         end
      end
   endtask

   task automatic test_sw_timeout();
      logic [16:0] exp [14];
      logic        rdy [14];
      exp = '{E_FETCH, E_DECODE, E_ADR_SW, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_MWTO,
              E_FETCHNR, E_FETCHNR, E_FETCHNR, E_FETCHNR, E_FETCHTO, E_FETCHNR};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk); bus.mem_ready = rdy[i]; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL sw_timeout[%0d] got %b want %b", i, sig(), exp[i]);
         end
      end
   endtask

   task automatic test_illegal_op();
      bus.op = 7'b1111111; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      checks++;
      if (sig() !== E_FETCH) begin
         errors++;
         $display("FAIL illegal_fetch got %b want %b", sig(), E_FETCH);
      end
      @(negedge clk); #1;
      checks++;
      if (sig() !== E_DECODE) begin
         errors++;
         $display("FAIL illegal_decode got %b want %b", sig(), E_DECODE);
      end
`ifdef MC_CTRL_ILLEGAL_OP_EN
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (sig() !== E_ZERO || bus.illegal_instr !== 1'b1) begin
            errors++;
            $display("FAIL illegal_stuck[%0d] got %b/%b want %b/1", i, sig(), bus.illegal_instr, E_ZERO);
         end
      end
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (bus.illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL illegal_reset got %b want 0", bus.illegal_instr);
      end
      @(negedge clk); bus.mem_ready = 1'b0; reset = 1'b1; #1;
      checks++;
      if (sig() !== E_FETCHNR || bus.illegal_instr !== 1'b0) begin
         errors++;
         $display("FAIL illegal_release got %b/%b want %b/0", sig(), bus.illegal_instr, E_FETCHNR);
      end
`else
      @(negedge clk); bus.mem_ready = 1'b0; #1;
      checks++;
      if (sig() !== E_FETCHNR) begin
         errors++;
         $display("FAIL nop_back_to_fetch got %b want %b", sig(), E_FETCHNR);
      end
`endif
   endtask

   task automatic test_reset_mid_write();
      logic [16:0] exp [4];
      logic        rdy [4];
      exp = '{E_FETCH, E_DECODE, E_ADR_SW, E_MEMWR};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
      bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); bus.mem_ready = rdy[i]; #1;
         checks++;
         if (sig() !== exp[i]) begin
            errors++;
            $display("FAIL reset_mid_setup[%0d] got %b want %b", i, sig(), exp[i]);
         end
      end
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (bus.mem_write !== 1'b0 || sig() !== E_ZERO) begin
         errors++;
         $display("FAIL reset_mid_abort got %b want %b", sig(), E_ZERO);
      end
      @(negedge clk); reset = 1'b1; #1;
      checks++;
      if (sig() !== E_FETCHNR) begin
         errors++;
         $display("FAIL reset_mid_release got %b want %b", sig(), E_FETCHNR);
      end
   endtask

   initial begin
      test_reset();
      test_rtype(3'b000, 1'b0, E_EXR_ADD);
      test_rtype(3'b000, 1'b1, E_EXR_SUB);
      test_rtype(3'b010, 1'b0, E_EXR_SLT);
      test_itype(3'b110, 1'b0, E_EXI_OR);
      test_itype(3'b000, 1'b1, E_EXI_ADD);
      test_lw_stall();
      test_jal();
      test_sw_ready_wins();
      test_sw_timeout();
      test_illegal_op();
      test_reset_mid_write();
      test_beq(1'b1);
      test_beq(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
